udma_adc_ts_gen: RTL and testbench

//  Timestamp event generator feeding the uDMA ADC timestamp channel, clocked on ts_clk_i.
//  - Keeps a free-running timestamp counter.
//  - Catches rising edges on NUM_CH event inputs and buffers (channel, stamp) records.
//  - Presents one record at a time on a toggle-valid interface. The record is held stable

---
 rtl/udma_adc_ts_pkg.sv | 21 ++
 rtl/udma_adc_ts_fifo.sv | 69 ++++++
 rtl/udma_adc_ts_gen.sv | 187 ++++++++++++++++++
 tb/tb_udma_adc_ts_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/udma_adc_ts_pkg.sv
// Shared types for the uDMA ADC timestamp generator.
//  ts_rec_t        : one buffered record {channel id, stamp}. Fields are sized to the
//                    widest supported configuration; users zero-extend on write and
//                    take the low bits on read.
//  ts_gen_state_e  : output hold FSM states.
package udma_adc_ts_pkg;

    localparam int TS_CHID_W_MAX = 8;
    localparam int TS_DATA_W_MAX = 32;

    typedef struct packed {
        logic [TS_CHID_W_MAX-1:0] chid;
        logic [TS_DATA_W_MAX-1:0] data;
    } ts_rec_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } ts_gen_state_e;

endpackage

// File: rtl/udma_adc_ts_fifo.sv
// Synchronous record FIFO with show-ahead read and synchronous flush.
//  clk_i/rst_ni  : clock, async active-low reset
//  clr_i         : flush (wins over push/pop)
//  push_i/data_i : write a record; ignored when full
//  pop_i/data_o  : data_o is the head record; pop_i drops it; ignored when empty
//  full_o/empty_o: occupancy flags
module udma_adc_ts_fifo
    import udma_adc_ts_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    clr_i,
    input  logic    push_i,
    input  ts_rec_t data_i,
    input  logic    pop_i,
    output ts_rec_t data_o,
    output logic    full_o,
    output logic    empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ts_rec_t         mem_q [DEPTH];
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o & ~clr_i;
    assign do_pop  = pop_i & ~empty_o & ~clr_i;
    assign data_o  = mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
            else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; only entries between rd and wr are ever observed.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/udma_adc_ts_gen.sv
// Timestamp event generator for the uDMA ADC timestamp channel.
//  ts_clk_i, rst_ni : clock, async active-low reset
//  en_i             : run counter and capture edges
//  clr_i            : sync clear of counter, pending, FIFO, hold FSM (outputs kept)
//  ch_evt_i         : per-channel event levels
//  ovf_clr_i        : clears the sticky overflow flag
//  ts_valid_o       : toggles once per presented record
//  ts_chid_o/ts_data_o : current record, stable for at least HOLD_CYCLES cycles
//  ovf_o            : sticky, an event was dropped
module udma_adc_ts_gen
    import udma_adc_ts_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int TS_DATA_WIDTH = 28,
    parameter int TS_CHID_WIDTH = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int HOLD_CYCLES   = 8
) (
    input  logic                     ts_clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic                     clr_i,
    input  logic [NUM_CH-1:0]        ch_evt_i,
    input  logic                     ovf_clr_i,
    output logic                     ts_valid_o,
    output logic [TS_CHID_WIDTH-1:0] ts_chid_o,
    output logic [TS_DATA_WIDTH-1:0] ts_data_o,
    output logic                     ovf_o
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES);

    logic [TS_DATA_WIDTH-1:0]             cnt_q, cnt_d;
    logic [NUM_CH-1:0]                    evt_q, edge_det;
    logic [NUM_CH-1:0]                    pend_q, pend_d;
    logic [NUM_CH-1:0][TS_DATA_WIDTH-1:0] stamp_q, stamp_d;
    logic [CH_W-1:0]                      rr_q, rr_d, gnt_idx, scan_idx;
    logic                                 gnt_vld, ovf_set, ovf_q, ovf_d;
    ts_gen_state_e                        state_q, state_d;
    logic [HOLD_W-1:0]                    hold_q, hold_d;
    logic                                 vld_q, vld_d, pop;
    logic [TS_CHID_WIDTH-1:0]             chid_q, chid_d;
    logic [TS_DATA_WIDTH-1:0]             data_q, data_d;
    ts_rec_t                              push_rec, head_rec;
    logic                                 fifo_full, fifo_empty;
    logic                                 unused_rec;

    // Edges are ignored while disabled or while clearing.
    assign edge_det = ch_evt_i & ~evt_q & {NUM_CH{en_i & ~clr_i}};

    assign cnt_d = clr_i ? '0 : (en_i ? cnt_q + TS_DATA_WIDTH'(1) : cnt_q);

    // Round-robin: first pending channel at or after rr_q, wrapping.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = rr_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!gnt_vld && pend_q[scan_idx] && !fifo_full && !clr_i) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
            scan_idx = (scan_idx == CH_W'(NUM_CH - 1)) ? '0 : scan_idx + CH_W'(1);
        end
    end

    // Arbitration restarts from channel 0 after a clear.
    always_comb begin
        rr_d = rr_q;
        if (clr_i) rr_d = '0;
        else if (gnt_vld) rr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
    end

    // A grant empties the slot in the same cycle, so an edge on the granted
    // channel refills it instead of overflowing.
    always_comb begin
        pend_d  = pend_q;
        stamp_d = stamp_q;
        ovf_set = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (gnt_vld && gnt_idx == CH_W'(c)) pend_d[c] = 1'b0;
            if (edge_det[c]) begin
                if (!pend_q[c] || (gnt_vld && gnt_idx == CH_W'(c))) begin
                    pend_d[c]  = 1'b1;
                    stamp_d[c] = cnt_q;
                end else begin
                    ovf_set = 1'b1;
                end
            end
        end
        if (clr_i) pend_d = '0;
    end

    // Set beats clear.
    assign ovf_d = ovf_set | (ovf_q & ~ovf_clr_i);

    assign push_rec.chid = TS_CHID_W_MAX'(gnt_idx);
    assign push_rec.data = TS_DATA_W_MAX'(stamp_q[gnt_idx]);

    udma_adc_ts_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (ts_clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .push_i  (gnt_vld),
        .data_i  (push_rec),
        .pop_i   (pop),
        .data_o  (head_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Upper record bits beyond the configured widths are always zero.
    assign unused_rec = ^head_rec;

    // Hold FSM: next state.
    always_comb begin
        state_d = state_q;
        if (clr_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (!fifo_empty) state_d = HOLD;
                HOLD:    if (hold_q == '0) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Hold FSM: outputs. A clear leaves the presented record untouched.
    always_comb begin
        pop    = 1'b0;
        hold_d = hold_q;
        vld_d  = vld_q;
        chid_d = chid_q;
        data_d = data_q;
        if (!clr_i) begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop    = 1'b1;
                        vld_d  = ~vld_q;
                        chid_d = head_rec.chid[TS_CHID_WIDTH-1:0];
                        data_d = head_rec.data[TS_DATA_WIDTH-1:0];
                        hold_d = HOLD_W'(HOLD_CYCLES - 1);
                    end
                end
                HOLD:    if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);
                default: ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge ts_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            evt_q   <= '0;
            pend_q  <= '0;
            stamp_q <= '0;
            rr_q    <= '0;
            ovf_q   <= 1'b0;
            state_q <= IDLE;
            hold_q  <= '0;
            vld_q   <= 1'b0;
            chid_q  <= '0;
            data_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            evt_q   <= ch_evt_i;
            pend_q  <= pend_d;
            stamp_q <= stamp_d;
            rr_q    <= rr_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            hold_q  <= hold_d;
            vld_q   <= vld_d;
            chid_q  <= chid_d;
            data_q  <= data_d;
        end
    end

    assign ts_valid_o = vld_q;
    assign ts_chid_o  = chid_q;
    assign ts_data_o  = data_q;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_udma_adc_ts_gen.sv
// Randomised + directed bench for udma_adc_ts_gen against a queue-based reference.
// The stamp width is narrowed so the counter reaches its wrap point in a short run.
module tb_udma_adc_ts_gen;
    localparam int NCH   = 4;
    localparam int DW    = 12;
    localparam int CW    = 4;
    localparam int DEPTH = 4;
    localparam int HOLD  = 8;
    localparam int CMASK = (1 << DW) - 1;

    logic            clk = 1'b0;
    logic            rst_n, en, clr, ovf_clr;
    logic [NCH-1:0]  evt;
    logic            vld, ovf;
    logic [CW-1:0]   chid;
    logic [DW-1:0]   data;

    udma_adc_ts_gen #(
        .NUM_CH(NCH), .TS_DATA_WIDTH(DW), .TS_CHID_WIDTH(CW),
        .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)
    ) dut (
        .ts_clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .ch_evt_i(evt),
        .ovf_clr_i(ovf_clr), .ts_valid_o(vld), .ts_chid_o(chid), .ts_data_o(data),
        .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {int chid; int data;} rec_t;
    rec_t           m_q[$];
    int             m_cnt, m_rr, m_hold, m_chid, m_data;
    int             m_stamp[NCH];
    bit             m_busy, m_vld, m_ovf;
    bit [NCH-1:0]   m_prev, m_pend;

    function automatic void m_reset();
        m_q.delete();
        m_cnt = 0; m_rr = 0; m_hold = 0; m_chid = 0; m_data = 0;
        m_busy = 0; m_vld = 0; m_ovf = 0; m_prev = '0; m_pend = '0;
        for (int c = 0; c < NCH; c++) m_stamp[c] = 0;
    endfunction

    function automatic void m_step(bit [NCH-1:0] e, bit en_in, bit clr_in, bit oclr_in);
        int  g = -1;
        bit  oset = 0;
        if (clr_in) begin
            m_cnt = 0; m_pend = '0; m_q.delete(); m_busy = 0; m_rr = 0;
            m_prev = e;
            if (oclr_in) m_ovf = 0;
            return;
        end
        // arbitration sees the FIFO occupancy from the start of the cycle
        if (m_q.size() < DEPTH)
            for (int i = 0; i < NCH; i++) begin
                int c = (m_rr + i) % NCH;
                if (g < 0 && m_pend[c]) g = c;
            end
        if (!m_busy) begin
            if (m_q.size() > 0) begin
                rec_t r = m_q.pop_front();
                m_vld = !m_vld; m_chid = r.chid; m_data = r.data;
                m_busy = 1; m_hold = HOLD - 1;
            end
        end else if (m_hold == 0) m_busy = 0;
        else m_hold--;
        if (g >= 0) begin
            m_q.push_back('{g, m_stamp[g]});
            m_pend[g] = 0;
            m_rr = (g + 1) % NCH;
        end
        for (int c = 0; c < NCH; c++)
            if (e[c] && !m_prev[c] && en_in) begin
                if (!m_pend[c]) begin m_pend[c] = 1; m_stamp[c] = m_cnt; end
                else oset = 1;
            end
        m_ovf = oset ? 1'b1 : (oclr_in ? 1'b0 : m_ovf);
        if (en_in) m_cnt = (m_cnt + 1) & CMASK;
        m_prev = e;
    endfunction

    // ---------------- drivers ----------------
    task automatic cycle();
        @(posedge clk);
        if (!rst_n) m_reset();
        else m_step(evt, en, clr, ovf_clr);
        @(negedge clk);
        check("valid", 64'(vld),  64'(m_vld));
        check("chid",  64'(chid), 64'(m_chid));
        check("data",  64'(data), 64'(m_data));
        check("ovf",   64'(ovf),  64'(m_ovf));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_cnt(input int target);
        int n = 0;
        while (m_cnt != target && n < 5000) begin cycle(); n++; end
    endtask

    // n = cycles run until the valid line changes, counting the cycle of the input edge
    task automatic wait_toggle(input string tag, input int max, output int n);
        logic v0 = vld;
        n = 0;
        while (vld === v0 && n < max) begin cycle(); n++; end
        check({tag, "_seen"}, 64'(vld !== v0), 64'(1));
    endtask

    task automatic clr_pulse();
        clr = 1; cycle(); clr = 0;
    endtask

    int n;

    initial begin
        rst_n = 0; en = 0; clr = 0; ovf_clr = 0; evt = '0;
        m_reset();
        #12;
        check("rst_valid", 64'(vld), 64'(0));
        check("rst_chid",  64'(chid), 64'(0));
        check("rst_data",  64'(data), 64'(0));
        check("rst_ovf",   64'(ovf), 64'(0));
        @(negedge clk);
        rst_n = 1; en = 1;

        // 1: single edge on ch2 at counter 0x10, toggles 2 cycles after sampling
        run_until_cnt(16);
        evt = 4'b0100;
        wait_toggle("t1", 20, n);
        check("t1_latency", 64'(n), 64'(3));
        check("t1_chid", 64'(chid), 64'(2));
        check("t1_data", 64'(data), 64'(16));

        // 2: ch0 and ch3 together at counter 5
        evt = '0;
        clr_pulse();
        run_until_cnt(5);
        evt = 4'b1001;
        wait_toggle("t2a", 20, n);
        check("t2a_latency", 64'(n), 64'(3));
        check("t2a_chid", 64'(chid), 64'(0));
        check("t2a_data", 64'(data), 64'(5));
        wait_toggle("t2b", 40, n);
        check("t2b_spacing", 64'(n), 64'(HOLD + 1));
        check("t2b_chid", 64'(chid), 64'(3));
        check("t2b_data", 64'(data), 64'(5));

        // 3: all channels pulse every 2 cycles into a saturated FIFO
        evt = '0;
        run(2 * (HOLD + 1) + 4);
        for (int i = 0; i < 60; i++) begin
            evt = (i % 2 == 0) ? 4'hF : 4'h0;
            cycle();
        end
        check("t3_ovf_set", 64'(ovf), 64'(1));
        evt = '0; ovf_clr = 1;
        cycle();
        ovf_clr = 0;
        check("t3_ovf_clr", 64'(ovf), 64'(0));
        run((DEPTH + NCH + 2) * (HOLD + 1));

        // 4: counter wrap; edge one cycle after the all-ones value stamps 0
        clr_pulse();
        run_until_cnt(CMASK);
        cycle();
        evt = 4'b0010;
        wait_toggle("t4", 20, n);
        check("t4_latency", 64'(n), 64'(3));
        check("t4_chid", 64'(chid), 64'(1));
        check("t4_data", 64'(data), 64'(0));

        // 5: clear during HOLD with three records queued
        evt = '0;
        run(HOLD + 2);
        clr_pulse();
        run_until_cnt(7);
        evt = 4'hF;
        wait_toggle("t5", 20, n);
        check("t5_first_chid", 64'(chid), 64'(0));
        run(2);
        clr_pulse();
        for (int i = 0; i < 30; i++) begin
            cycle();
            check("t5_hold_chid", 64'(chid), 64'(0));
            check("t5_hold_data", 64'(data), 64'(7));
        end
        evt = '0;
        cycle();
        clr_pulse();
        evt = 4'b0010;
        wait_toggle("t5_cnt0", 20, n);
        check("t5_cnt0_data", 64'(data), 64'(0));

        // 6: async reset in the middle of HOLD
        evt = '0;
        run(HOLD + 2);
        evt = 4'b1000;
        wait_toggle("t6pre", 20, n);
        run(3);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("t6_rst_valid", 64'(vld), 64'(0));
        check("t6_rst_chid",  64'(chid), 64'(0));
        check("t6_rst_data",  64'(data), 64'(0));
        check("t6_rst_ovf",   64'(ovf), 64'(0));
        m_reset();
        @(negedge clk);
        evt = '0;
        run(2);
        rst_n = 1;
        run_until_cnt(16);
        evt = 4'b0100;
        wait_toggle("t6", 20, n);
        check("t6_latency", 64'(n), 64'(3));
        check("t6_chid", 64'(chid), 64'(2));
        check("t6_data", 64'(data), 64'(16));

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 3) == 0) evt[c] = ~evt[c];
            en      = ($urandom_range(0, 15) != 0);
            clr     = ($urandom_range(0, 149) == 0);
            ovf_clr = ($urandom_range(0, 31) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
